// File: rtl/video_timing_pkg.sv
// video_timing_pkg: board timing table and modular sync-position helper
package video_timing_pkg;

    localparam int TW          = 10;
    localparam int TABLE_MODES = 4;

    typedef struct packed {
        logic [TW-1:0] htotal;
        logic [TW-1:0] hbl_s;
        logic [TW-1:0] hbl_e;
        logic [TW-1:0] hs_s;
        logic [TW-1:0] hs_e;
        logic [TW-1:0] vtotal;
        logic [TW-1:0] vbl_s;
        logic [TW-1:0] vbl_e;
        logic [TW-1:0] vs_s;
        logic [TW-1:0] vs_e;
    } timing_t;

    localparam timing_t MODE_TABLE [TABLE_MODES] = '{
        '{10'd386, 10'd349, 10'd29, 10'd363, 10'd379, 10'd262, 10'd256, 10'd16, 10'd0,   10'd8},
        '{10'd386, 10'd333, 10'd45, 10'd363, 10'd379, 10'd262, 10'd240, 10'd16, 10'd0,   10'd8},
        '{10'd386, 10'd285, 10'd29, 10'd363, 10'd379, 10'd262, 10'd240, 10'd16, 10'd0,   10'd8},
        '{10'd383, 10'd293, 10'd37, 10'd335, 10'd351, 10'd261, 10'd240, 10'd16, 10'd244, 10'd247}
    };

    // Shift a position by a signed offset, folding the result back into 0..total
    function automatic int wrap_add(input int base, input int off, input int total);
        int s;
        s = base + off;
        if (s < 0)
            s = s + total + 1;
        else if (s > total)
            s = s - total - 1;
        return s;
    endfunction

endpackage

// File: rtl/video_sync_window.sv
// video_sync_window: wrap-aware sync flag whose start/end positions reload at frame wrap
module video_sync_window
    import video_timing_pkg::*;
#(
    parameter int W     = 9,
    parameter int RST_S = 0,
    parameter int RST_E = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_tick,
    input  logic         i_cmp,
    input  logic         i_load,
    input  logic [W-1:0] i_cnt,
    input  logic [W-1:0] i_base_s,
    input  logic [W-1:0] i_base_e,
    input  logic [W-1:0] i_total,
    input  logic [W-1:0] i_off,
    output logic         o_sync
);

    logic [W-1:0] r_s;
    logic [W-1:0] r_e;
    logic         r_sync;
    logic [W-1:0] w_s;
    logic [W-1:0] w_e;

    // Offset-adjusted window for the frame about to start
    always_comb begin
        w_s = W'(wrap_add(int'(i_base_s), int'($signed(i_off)), int'(i_total)));
        w_e = W'(wrap_add(int'(i_base_e), int'($signed(i_off)), int'(i_total)));
    end

    // Start wins over end, so a window with start > end simply stays high across the wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s    <= W'(RST_S);
            r_e    <= W'(RST_E);
            r_sync <= 1'b0;
        end else if (i_tick) begin
            if (i_cmp)
                r_sync <= (i_cnt == r_s) ? 1'b1 : (i_cnt == r_e) ? 1'b0 : r_sync;
            if (i_load) begin
                r_s <= w_s;
                r_e <= w_e;
            end
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/video_timing_multi.sv
// video_timing_multi: multi-mode raster timing generator with frame-synchronous mode/offset updates
module video_timing_multi
    import video_timing_pkg::*;
#(
    parameter int HW     = 9,
    parameter int VW     = 9,
    parameter int NMODES = 4,
    parameter int MW     = $clog2(NMODES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_pix_en,
    input  logic [MW-1:0] mode,
    input  logic [HW-1:0] hs_offset,
    input  logic [VW-1:0] vs_offset,
    output logic [HW-1:0] hc,
    output logic [VW-1:0] vc,
    output logic          hbl,
    output logic          vbl,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic [MW-1:0] mode_act
);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_hbl;
    logic          r_vbl;
    logic          r_de;
    logic          r_ls;
    logic          r_fs;
    logic [MW-1:0] r_mode;
    logic [31:0]   w_mode_ext;
    logic [MW-1:0] w_mode_sel;
    logic [HW-1:0] w_htot, w_hbl_s, w_hbl_e, w_nhtot, w_nhs_s, w_nhs_e;
    logic [VW-1:0] w_vtot, w_vbl_s, w_vbl_e, w_nvtot, w_nvs_s, w_nvs_e;
    logic          w_hend, w_vend, w_wrap, w_hbl_n, w_vbl_n;

    // Active entry drives the counters and blanks; the requested entry feeds the sync reload
    always_comb begin
        w_mode_ext = 32'(mode);
        w_mode_sel = (w_mode_ext < 32'(NMODES)) ? mode : '0;
        w_htot     = HW'(MODE_TABLE[r_mode].htotal);
        w_hbl_s    = HW'(MODE_TABLE[r_mode].hbl_s);
        w_hbl_e    = HW'(MODE_TABLE[r_mode].hbl_e);
        w_vtot     = VW'(MODE_TABLE[r_mode].vtotal);
        w_vbl_s    = VW'(MODE_TABLE[r_mode].vbl_s);
        w_vbl_e    = VW'(MODE_TABLE[r_mode].vbl_e);
        w_nhtot    = HW'(MODE_TABLE[w_mode_sel].htotal);
        w_nhs_s    = HW'(MODE_TABLE[w_mode_sel].hs_s);
        w_nhs_e    = HW'(MODE_TABLE[w_mode_sel].hs_e);
        w_nvtot    = VW'(MODE_TABLE[w_mode_sel].vtotal);
        w_nvs_s    = VW'(MODE_TABLE[w_mode_sel].vs_s);
        w_nvs_e    = VW'(MODE_TABLE[w_mode_sel].vs_e);
        w_hend     = r_h == w_htot;
        w_vend     = r_v == w_vtot;
        w_wrap     = w_hend & w_vend;
        w_hbl_n    = (r_h == w_hbl_s) ? 1'b1 : (r_h == w_hbl_e) ? 1'b0 : r_hbl;
        w_vbl_n    = !w_hend ? r_vbl : (r_v == w_vbl_s) ? 1'b1 : (r_v == w_vbl_e) ? 1'b0 : r_vbl;
    end

    // Counters, blanks, pulses and the frame-synchronous mode latch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h    <= '0;
            r_v    <= '0;
            r_hbl  <= 1'b0;
            r_vbl  <= 1'b0;
            r_de   <= 1'b0;
            r_ls   <= 1'b0;
            r_fs   <= 1'b0;
            r_mode <= '0;
        end else if (clk_pix_en) begin
            r_h   <= w_hend ? '0 : r_h + 1'b1;
            r_v   <= w_wrap ? '0 : w_hend ? r_v + 1'b1 : r_v;
            r_hbl <= w_hbl_n;
            r_vbl <= w_vbl_n;
            r_de  <= ~w_hbl_n & ~w_vbl_n;
            r_ls  <= w_hend;
            r_fs  <= w_wrap;
            if (w_wrap)
                r_mode <= w_mode_sel;
        end
    end

    video_sync_window #(
        .W     (HW),
        .RST_S (int'(MODE_TABLE[0].hs_s)),
        .RST_E (int'(MODE_TABLE[0].hs_e))
    ) u_hs (
        .clk      (clk),
        .reset    (reset),
        .i_tick   (clk_pix_en),
        .i_cmp    (1'b1),
        .i_load   (w_wrap),
        .i_cnt    (r_h),
        .i_base_s (w_nhs_s),
        .i_base_e (w_nhs_e),
        .i_total  (w_nhtot),
        .i_off    (hs_offset),
        .o_sync   (hsync)
    );

    video_sync_window #(
        .W     (VW),
        .RST_S (int'(MODE_TABLE[0].vs_s)),
        .RST_E (int'(MODE_TABLE[0].vs_e))
    ) u_vs (
        .clk      (clk),
        .reset    (reset),
        .i_tick   (clk_pix_en),
        .i_cmp    (w_hend),
        .i_load   (w_wrap),
        .i_cnt    (r_v),
        .i_base_s (w_nvs_s),
        .i_base_e (w_nvs_e),
        .i_total  (w_nvtot),
        .i_off    (vs_offset),
        .o_sync   (vsync)
    );

    assign hc          = r_h;
    assign vc          = r_v;
    assign hbl         = r_hbl;
    assign vbl         = r_vbl;
    assign de          = r_de;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
    assign mode_act    = r_mode;

endmodule

// File: tb/tb_video_timing_multi.sv
// tb_video_timing_multi: directed raster checks through an expectation queue and sampling monitor
module tb_video_timing_multi;

    localparam int F = 101781;
    localparam int L = 387;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_pix_en;
    logic [1:0] mode;
    logic [8:0] hs_offset;
    logic [8:0] vs_offset;
    logic [8:0] hc;
    logic [8:0] vc;
    logic       hbl, vbl, hsync, vsync, de, line_start, frame_start;
    logic [1:0] mode_act;

    typedef struct {
        string name;
        int hc, vc, hbl, vbl, hs, vs, de, ls, fs, m;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   tcount   = 0;

    video_timing_multi dut (
        .clk         (clk),
        .reset       (reset),
        .clk_pix_en  (clk_pix_en),
        .mode        (mode),
        .hs_offset   (hs_offset),
        .vs_offset   (vs_offset),
        .hc          (hc),
        .vc          (vc),
        .hbl         (hbl),
        .vbl         (vbl),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .line_start  (line_start),
        .frame_start (frame_start),
        .mode_act    (mode_act)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input string f, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s.%s got=%0d exp=%0d", n, f, a, e);
        end
    endtask

    task automatic push(input string n, input int h, input int v, input int hb, input int vb,
                        input int hs, input int vs, input int d, input int ls, input int fs,
                        input int m);
        exp_t e;
        e.name = n; e.hc = h; e.vc = v; e.hbl = hb; e.vbl = vb;
        e.hs = hs; e.vs = vs; e.de = d; e.ls = ls; e.fs = fs; e.m = m;
        q.push_back(e);
    endtask

    task automatic go(input int f, input int v, input int h);
        int tgt;
        tgt = f * F + v * L + h;
        repeat (tgt - tcount) @(negedge clk);
        tcount = tgt;
    endtask

    task automatic qtick(input int n);
        repeat (n) begin
            clk_pix_en = 1'b1;
            @(negedge clk);
            clk_pix_en = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "hc", int'(hc), e.hc);
                chk(e.name, "vc", int'(vc), e.vc);
                chk(e.name, "hbl", int'(hbl), e.hbl);
                chk(e.name, "vbl", int'(vbl), e.vbl);
                chk(e.name, "hsync", int'(hsync), e.hs);
                chk(e.name, "vsync", int'(vsync), e.vs);
                chk(e.name, "de", int'(de), e.de);
                chk(e.name, "line_start", int'(line_start), e.ls);
                chk(e.name, "frame_start", int'(frame_start), e.fs);
                chk(e.name, "mode_act", int'(mode_act), e.m);
            end
        end
    end

    initial begin
        reset = 1'b1; clk_pix_en = 1'b1; mode = 2'd0; hs_offset = 9'd0; vs_offset = 9'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push("reset",        0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        go(0, 0, 1);   push("f0_h1",        1,   0, 0, 0, 0, 0, 1, 0, 0, 0);
        go(0, 0, 29);  push("f0_h29",       29,  0, 0, 0, 0, 0, 1, 0, 0, 0);
        go(0, 0, 350); push("f0_hbl_on",    350, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        go(0, 0, 364); push("f0_hs_on",     364, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        go(0, 0, 379); push("f0_hs_last",   379, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        go(0, 0, 380); push("f0_hs_off",    380, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        go(0, 1, 0);   push("f0_line1",     0,   1, 1, 0, 0, 1, 0, 1, 0, 0);
        go(0, 1, 29);  push("f0_l1_h29",    29,  1, 1, 0, 0, 1, 0, 0, 0, 0);
        go(0, 1, 30);  push("f0_l1_h30",    30,  1, 0, 0, 0, 1, 1, 0, 0, 0);
        go(0, 8, 386); push("f0_vs_last",   386, 8, 1, 0, 0, 1, 0, 0, 0, 0);
        go(0, 9, 0);   push("f0_vs_off",    0,   9, 1, 0, 0, 0, 0, 1, 0, 0);
        go(0, 100, 5); push("f0_v100",      5, 100, 1, 0, 0, 0, 0, 0, 0, 0);
        mode = 2'd1; hs_offset = 9'd30; vs_offset = 9'h1FC;
        go(0, 101, 7);   push("f0_hs_old_lo", 7,   101, 1, 0, 0, 0, 0, 0, 0, 0);
        go(0, 101, 364); push("f0_hs_old_hi", 364, 101, 1, 0, 1, 0, 0, 0, 0, 0);
        go(0, 241, 100); push("f0_vbl_old",   100, 241, 0, 0, 0, 0, 1, 0, 0, 0);
        go(0, 256, 386); push("f0_vbl_pre",   386, 256, 1, 0, 0, 0, 0, 0, 0, 0);
        go(0, 257, 0);   push("f0_vbl_on",    0,   257, 1, 1, 0, 0, 0, 1, 0, 0);
        go(0, 262, 386); push("f0_last",      386, 262, 1, 1, 0, 0, 0, 0, 0, 0);
        go(1, 0, 0);     push("f1_start",     0,   0,   1, 1, 0, 0, 0, 1, 1, 1);
        go(1, 0, 1);     push("f1_h1",        1,   0,   1, 1, 0, 0, 0, 0, 0, 1);
        go(1, 1, 0);     push("f1_line1",     0,   1,   1, 1, 0, 0, 0, 1, 0, 1);
        go(1, 17, 0);    push("f1_vbl_off",   0,   17,  1, 0, 0, 0, 0, 1, 0, 1);
        go(1, 50, 7);    push("f1_hs_on",     7,   50,  1, 0, 1, 0, 0, 0, 0, 1);
        go(1, 50, 22);   push("f1_hs_last",   22,  50,  1, 0, 1, 0, 0, 0, 0, 1);
        go(1, 50, 23);   push("f1_hs_off",    23,  50,  1, 0, 0, 0, 0, 0, 0, 1);
        go(1, 50, 46);   push("f1_hbl_off",   46,  50,  0, 0, 0, 0, 1, 0, 0, 1);
        go(1, 50, 334);  push("f1_hbl_on",    334, 50,  1, 0, 0, 0, 0, 0, 0, 1);
        go(1, 50, 364);  push("f1_hs_old",    364, 50,  1, 0, 0, 0, 0, 0, 0, 1);
        go(1, 200, 10);  push("f1_v200",      10,  200, 1, 0, 1, 0, 0, 0, 0, 1);
        hs_offset = 9'h1F3;
        go(1, 201, 10);  push("f1_hs_hold",   10,  201, 1, 0, 1, 0, 0, 0, 0, 1);
        go(1, 240, 386); push("f1_vbl_pre",   386, 240, 1, 0, 0, 0, 0, 0, 0, 1);
        go(1, 241, 0);   push("f1_vbl_on",    0,   241, 1, 1, 0, 0, 0, 1, 0, 1);
        go(1, 259, 386); push("f1_vs_pre",    386, 259, 1, 1, 0, 0, 0, 0, 0, 1);
        go(1, 260, 0);   push("f1_vs_on",     0,   260, 1, 1, 0, 1, 0, 1, 0, 1);
        go(1, 262, 386); push("f1_last",      386, 262, 1, 1, 0, 1, 0, 0, 0, 1);
        go(2, 0, 0);     push("f2_start",     0,   0,   1, 1, 0, 1, 0, 1, 1, 1);
        go(2, 0, 10);    push("f2_hs_new",    10,  0,   1, 1, 0, 1, 0, 0, 0, 1);
        go(2, 4, 386);   push("f2_vs_last",   386, 4,   1, 1, 0, 1, 0, 0, 0, 1);
        go(2, 5, 0);     push("f2_vs_off",    0,   5,   1, 1, 0, 0, 0, 1, 0, 1);
        go(2, 10, 350);  push("f2_hs_pre",    350, 10,  1, 1, 0, 0, 0, 0, 0, 1);
        go(2, 10, 351);  push("f2_hs_on",     351, 10,  1, 1, 1, 0, 0, 0, 0, 1);
        go(2, 10, 366);  push("f2_hs_last",   366, 10,  1, 1, 1, 0, 0, 0, 0, 1);
        go(2, 10, 367);  push("f2_hs_off",    367, 10,  1, 1, 0, 0, 0, 0, 0, 1);
        go(2, 17, 0);    push("f2_vbl_off",   0,   17,  1, 0, 0, 0, 0, 1, 0, 1);
        go(2, 20, 200);  push("f2_pre_rst",   200, 20,  0, 0, 0, 0, 1, 0, 0, 1);
        clk_pix_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        push("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        push("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        qtick(1);
        push("q_h1", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        qtick(348);
        clk_pix_en = 1'b1;
        @(negedge clk);
        clk_pix_en = 1'b0;
        push("q_tick350", 350, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        push("q_hold350", 350, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        qtick(36);
        clk_pix_en = 1'b1;
        @(negedge clk);
        clk_pix_en = 1'b0;
        push("q_line1", 0, 1, 1, 0, 0, 1, 0, 1, 0, 0);
        repeat (3) @(negedge clk);
        push("q_line1_hold", 0, 1, 1, 0, 0, 1, 0, 1, 0, 0);
        clk_pix_en = 1'b1;
        @(negedge clk);
        clk_pix_en = 1'b0;
        push("q_h1_l1", 1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
